// File: rtl/map_mem_arb.sv
`timescale 1ns/1ps
// map_mem_arb: shares one memory port between the mapper CPU path and the FMV DMA writer.
// CPU has fixed priority; a wait counter forces a DMA grant after DMA_MAX_WAIT CPU grants.
module map_mem_arb #(
  parameter int AW           = 23,
  parameter int DW           = 16,
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          grant_dma
);
  localparam int            CW       = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(DMA_MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          grant_dma_q, grant_dma_d;

  logic cpu_elig_s, dma_elig_s, arb_open_s, dma_win_s, cpu_win_s;

  // Winner select; the cycle carrying an ack pulse is a dead cycle so mem_req always idles once.
  always_comb begin
    cpu_elig_s = cpu_req & ~cpu_ack_q;
    dma_elig_s = dma_req & ~dma_ack_q;
    arb_open_s = (state_q == ST_IDLE) & ~cpu_ack_q & ~dma_ack_q;
    dma_win_s  = arb_open_s & dma_elig_s & (~cpu_elig_s | (wait_cnt_q == WAIT_MAX));
    cpu_win_s  = arb_open_s & cpu_elig_s & ~dma_win_s;
  end

  // Transaction FSM: launch the winner, then hold mem_* until the memory acks.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_dma_d = grant_dma_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dma_win_s) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dma_we;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          grant_dma_d = 1'b1;
          state_d     = ST_DMA;
        end else if (cpu_win_s) begin
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          grant_dma_d = 1'b0;
          state_d     = ST_CPU;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CPU: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
          cpu_ack_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_CPU;
        end
      end
      ST_DMA: begin
        if (mem_ack) begin
          if (!mem_we_q) begin
            dma_rdata_d = mem_rdata;
          end else begin
            dma_rdata_d = dma_rdata_q;
          end
          dma_ack_d   = 1'b1;
          mem_req_d   = 1'b0;
          grant_dma_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DMA;
        end
      end
      default: begin
        mem_req_d   = 1'b0;
        grant_dma_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Starvation counter: counts CPU grants taken while the DMA waits.
  always_comb begin
    if (!dma_req) begin
      wait_cnt_d = {CW{1'b0}};
    end else if (dma_win_s) begin
      wait_cnt_d = {CW{1'b0}};
    end else if (cpu_win_s && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= {CW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      cpu_rdata_q <= {DW{1'b0}};
      dma_rdata_q <= {DW{1'b0}};
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      grant_dma_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      grant_dma_q <= grant_dma_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign grant_dma = grant_dma_q;
endmodule

// File: tb/tb_map_mem_arb.sv
`timescale 1ns/1ps
// Directed bench for map_mem_arb: one task per scenario, hand-computed expectations.
module tb_map_mem_arb;
  localparam int AW = 23;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we, mem_ack;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic          cpu_ack, dma_ack, mem_req, mem_we, grant_dma;
  logic [AW-1:0] mem_addr;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_dma_rdata;

  always #5 clk = ~clk;

  map_mem_arb dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant_dma(grant_dma)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick; tick;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0b want 0", mem_req); else pass_cnt++;
    total_cnt++; if ({cpu_ack, dma_ack, grant_dma} !== 3'b000) $display("FAIL reset_acks got %03b want 000", {cpu_ack, dma_ack, grant_dma}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 23'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else pass_cnt++;
    total_cnt++; if ({cpu_rdata, dma_rdata} !== 32'h0) $display("FAIL reset_rdata got %h want 0", {cpu_rdata, dma_rdata}); else pass_cnt++;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_cpu_read;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000100;
    tick;
    total_cnt++; if ({mem_req, mem_we, grant_dma} !== 3'b100) $display("FAIL cpu_rd_grant got %03b want 100", {mem_req, mem_we, grant_dma}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 23'h000100) $display("FAIL cpu_rd_addr got %h want 000100", mem_addr); else pass_cnt++;
    tick; tick;
    total_cnt++; if ({mem_req, cpu_ack} !== 2'b10) $display("FAIL cpu_rd_wait got %02b want 10", {mem_req, cpu_ack}); else pass_cnt++;
    mem_rdata = 16'hA55A; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; cpu_req = 1'b0;
    total_cnt++; if ({cpu_ack, mem_req} !== 2'b10) $display("FAIL cpu_rd_ack got %02b want 10", {cpu_ack, mem_req}); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 16'hA55A) $display("FAIL cpu_rd_data got %h want a55a", cpu_rdata); else pass_cnt++;
    tick;
    total_cnt++; if ({cpu_ack, mem_req} !== 2'b00) $display("FAIL cpu_rd_pulse got %02b want 00", {cpu_ack, mem_req}); else pass_cnt++;
  endtask

  task automatic test_priority;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000200; cpu_wdata = 16'h1111;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 23'h000300; dma_wdata = 16'h2222;
    tick;
    total_cnt++; if ({mem_req, grant_dma} !== 2'b10 || mem_addr !== 23'h000200) $display("FAIL prio_cpu_first got req/gnt %02b addr %h want 10/000200", {mem_req, grant_dma}, mem_addr); else pass_cnt++;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; cpu_req = 1'b0;
    total_cnt++; if ({cpu_ack, dma_ack} !== 2'b10) $display("FAIL prio_cpu_ack got %02b want 10", {cpu_ack, dma_ack}); else pass_cnt++;
    tick;
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL prio_gap got %0b want 0", mem_req); else pass_cnt++;
    tick;
    total_cnt++; if ({mem_req, grant_dma} !== 2'b11 || mem_wdata !== 16'h2222 || mem_addr !== 23'h000300) $display("FAIL prio_dma_next got req/gnt %02b addr %h wd %h want 11/000300/2222", {mem_req, grant_dma}, mem_addr, mem_wdata); else pass_cnt++;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; dma_req = 1'b0;
    total_cnt++; if ({dma_ack, grant_dma, mem_req} !== 3'b100) $display("FAIL prio_dma_ack got %03b want 100", {dma_ack, grant_dma, mem_req}); else pass_cnt++;
    tick;
  endtask

  task automatic test_starvation;
    logic got;
    logic exp_d;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000400;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h000500;
    for (int i = 0; i < 18; i++) begin
      got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        tick;
        if (mem_req) got = 1'b1;
      end
      if (!got) begin
        total_cnt++;
        $display("FAIL starve_timeout grant %0d got no mem_req want mem_req=1", i);
        break;
      end
      exp_d = ((i % 9) == 8);
      total_cnt++; if (grant_dma !== exp_d) $display("FAIL starve_grant_%0d got %0b want %0b", i, grant_dma, exp_d); else pass_cnt++;
      mem_rdata = 16'hC000 + 16'(i); mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      total_cnt++; if ({cpu_ack, dma_ack} !== (exp_d ? 2'b01 : 2'b10)) $display("FAIL starve_ack_%0d got %02b want %02b", i, {cpu_ack, dma_ack}, (exp_d ? 2'b01 : 2'b10)); else pass_cnt++;
      if (exp_d) exp_dma_rdata = 16'hC000 + 16'(i);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick;
    total_cnt++; if (dma_rdata !== exp_dma_rdata) $display("FAIL starve_dma_rdata got %h want %h", dma_rdata, exp_dma_rdata); else pass_cnt++;
  endtask

  task automatic test_dma_write;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 23'h7FFFFF; dma_wdata = 16'h1234;
    tick;
    total_cnt++; if ({mem_req, mem_we, grant_dma} !== 3'b111) $display("FAIL dma_wr_grant got %03b want 111", {mem_req, mem_we, grant_dma}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 23'h7FFFFF || mem_wdata !== 16'h1234) $display("FAIL dma_wr_fields got %h/%h want 7fffff/1234", mem_addr, mem_wdata); else pass_cnt++;
    dma_addr = 23'h000001; dma_wdata = 16'h9999;
    tick;
    total_cnt++; if (mem_addr !== 23'h7FFFFF || mem_wdata !== 16'h1234) $display("FAIL dma_wr_hold got %h/%h want 7fffff/1234", mem_addr, mem_wdata); else pass_cnt++;
    mem_rdata = 16'hBEEF; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; dma_req = 1'b0;
    total_cnt++; if ({dma_ack, cpu_ack, mem_req} !== 3'b100) $display("FAIL dma_wr_ack got %03b want 100", {dma_ack, cpu_ack, mem_req}); else pass_cnt++;
    total_cnt++; if (dma_rdata !== exp_dma_rdata) $display("FAIL dma_wr_rdata got %h want %h", dma_rdata, exp_dma_rdata); else pass_cnt++;
    tick;
  endtask

  task automatic test_reset_mid;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000040;
    tick;
    total_cnt++; if (mem_req !== 1'b1) $display("FAIL rmid_grant got %0b want 1", mem_req); else pass_cnt++;
    tick; tick;
    rst = 1'b1;
    #1;
    total_cnt++; if ({mem_req, cpu_ack} !== 2'b00) $display("FAIL rmid_async got %02b want 00", {mem_req, cpu_ack}); else pass_cnt++;
    tick;
    rst = 1'b0;
    total_cnt++; if (cpu_ack !== 1'b0) $display("FAIL rmid_no_ack got %0b want 0", cpu_ack); else pass_cnt++;
    tick;
    total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 23'h000040) $display("FAIL rmid_regrant got %0b/%h want 1/000040", mem_req, mem_addr); else pass_cnt++;
    mem_rdata = 16'h5A5A; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; cpu_req = 1'b0;
    total_cnt++; if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h5A5A) $display("FAIL rmid_ack got %0b/%h want 1/5a5a", cpu_ack, cpu_rdata); else pass_cnt++;
    tick;
  endtask

  task automatic test_spurious_ack;
    mem_rdata = 16'hFFFF; mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    total_cnt++; if ({cpu_ack, dma_ack, mem_req, grant_dma} !== 4'b0000) $display("FAIL spur_ctrl got %04b want 0000", {cpu_ack, dma_ack, mem_req, grant_dma}); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 16'h5A5A || dma_rdata !== 16'h0000) $display("FAIL spur_rdata got %h/%h want 5a5a/0000", cpu_rdata, dma_rdata); else pass_cnt++;
    tick;
    total_cnt++; if ({cpu_ack, dma_ack, mem_req} !== 3'b000 || mem_addr !== 23'h000040) $display("FAIL spur_after got %03b/%h want 000/000040", {cpu_ack, dma_ack, mem_req}, mem_addr); else pass_cnt++;
  endtask

  initial begin
    exp_dma_rdata = 16'h0000;
    test_reset;
    test_cpu_read;
    test_priority;
    test_starvation;
    test_dma_write;
    test_reset_mid;
    test_spurious_ack;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
